// File: rtl/status_pkg.sv
// Shared definitions for the status monitor: channel limit, event word layout
// and a constant clog2 helper for sizing counters and pointers.
package status_pkg;

   localparam int STATUS_MAX_IN = 12;
   localparam int CHG_LSB       = 12;
   localparam int STATE_LSB     = 0;
   localparam int EVENT_W       = 24;

   typedef struct packed {
      logic [STATUS_MAX_IN-1:0] changed;
      logic [STATUS_MAX_IN-1:0] state;
   } status_event_t;

   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/status_debounce.sv
// One status channel: polarity adjust, 2-flop synchroniser and a counter that
// accepts a new level only after DEB_CYCLES consecutive differing samples.
module status_debounce
   import status_pkg::*;
#(
   parameter int DEB_CYCLES = 50000,
   parameter bit INVERT     = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic deb
);

   localparam int CW = clog2(DEB_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

   logic sync1;
   logic sync2;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= raw ^ INVERT;
         sync2 <= sync1;
      end
   end

   // Any sample agreeing with the accepted level restarts the stability count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         deb <= 1'b0;
      end else if (sync2 == deb) begin
         cnt <= '0;
      end else if (cnt == CNT_LAST) begin
         cnt <= '0;
         deb <= ~deb;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/status_monitor.sv
// Debounced status reporter: queues every change of the debounced vector in a
// small FWFT FIFO. Optional heartbeat words: define STATUS_MONITOR_HEARTBEAT_EN.
module status_monitor
   import status_pkg::*;
#(
   parameter int                       N_IN             = 6,
   parameter logic [STATUS_MAX_IN-1:0] INV_MASK         = 12'h00F,
   parameter int                       DEB_CYCLES       = 50000,
   parameter int                       FIFO_DEPTH       = 4,
   parameter int                       HEARTBEAT_CYCLES = 10000000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_IN-1:0]    raw_in,
   output logic [EVENT_W-1:0] out_data,
   output logic               out_wr,
   input  logic               out_ack,
   output logic               overflow,
   input  logic               clr_ovf,
   output logic [N_IN-1:0]    state
);

   localparam int AW = clog2(FIFO_DEPTH);

   logic [N_IN-1:0]          deb;
   logic [STATUS_MAX_IN-1:0] deb_ext;
   logic [STATUS_MAX_IN-1:0] chg;
   logic [STATUS_MAX_IN-1:0] last_reported;
   logic [STATUS_MAX_IN-1:0] pending_mask;
   logic [AW:0]              wr_ptr;
   logic [AW:0]              rd_ptr;
   logic [AW:0]              rd_next;
   status_event_t            mem [FIFO_DEPTH];
   status_event_t            push_word;
   status_event_t            head_next;
   logic full, pop, space, push, coalesce, load_last, clr_pending, hb_tick;

   if (N_IN < 1 || N_IN > STATUS_MAX_IN || DEB_CYCLES < 1 || FIFO_DEPTH < 2 ||
       FIFO_DEPTH > 16 || (1 << AW) != FIFO_DEPTH || HEARTBEAT_CYCLES < 1) begin : g_bad_params
      $error("status_monitor: parameter out of range");
   end

   for (genvar g = 0; g < N_IN; g++) begin : g_chan
      status_debounce #(
         .DEB_CYCLES (DEB_CYCLES),
         .INVERT     (INV_MASK[g])
      ) u_deb (
         .clk   (clk),
         .rst_n (rst_n),
         .raw   (raw_in[g]),
         .deb   (deb[g])
      );
   end

   always_comb begin
      deb_ext = '0;
      deb_ext[N_IN-1:0] = deb;
   end

   assign state   = deb;
   assign chg     = deb_ext ^ last_reported;
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop     = out_wr & out_ack;
   assign space   = !full || pop;
   assign rd_next = rd_ptr + {{AW{1'b0}}, pop};

`ifdef STATUS_MONITOR_HEARTBEAT_EN
   localparam int HW = clog2(HEARTBEAT_CYCLES + 1);
   localparam logic [HW-1:0] HB_LAST = HW'(HEARTBEAT_CYCLES - 1);
   logic [HW-1:0] hb_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hb_cnt <= '0;
      end else if (hb_cnt == HB_LAST) begin
         hb_cnt <= '0;
      end else begin
         hb_cnt <= hb_cnt + HW'(1);
      end
   end

   assign hb_tick = (hb_cnt == HB_LAST);
`else
   assign hb_tick = 1'b0;
`endif

   // Changes win over a pending flush, which wins over a heartbeat; a change
   // that finds no room is folded into pending_mask instead of being dropped.
   always_comb begin
      push        = 1'b0;
      coalesce    = 1'b0;
      load_last   = 1'b0;
      clr_pending = 1'b0;
      push_word   = '0;
      if (chg != '0) begin
         load_last = 1'b1;
         if (space) begin
            push              = 1'b1;
            clr_pending       = 1'b1;
            push_word.changed = chg | pending_mask;
            push_word.state   = deb_ext;
         end else begin
            coalesce = 1'b1;
         end
      end else if (pending_mask != '0 && space) begin
         push              = 1'b1;
         clr_pending       = 1'b1;
         push_word.changed = pending_mask;
         push_word.state   = deb_ext;
      end else if (hb_tick && space) begin
         push            = 1'b1;
         push_word.state = deb_ext;
      end
   end

   // Words pushed this cycle are excluded so out_wr rises one cycle after the write.
   always_comb begin
      head_next = '0;
      if (wr_ptr != rd_next) begin
         head_next = mem[rd_next[AW-1:0]];
      end
   end

   // Storage needs no reset: the pointers alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= push_word;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         out_wr   <= 1'b0;
         out_data <= '0;
      end else begin
         wr_ptr <= wr_ptr + {{AW{1'b0}}, push};
         rd_ptr <= rd_next;
         out_wr <= (wr_ptr != rd_next);
         out_data[CHG_LSB +: STATUS_MAX_IN]   <= head_next.changed;
         out_data[STATE_LSB +: STATUS_MAX_IN] <= head_next.state;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_reported <= '0;
         pending_mask  <= '0;
         overflow      <= 1'b0;
      end else begin
         if (load_last) begin
            last_reported <= deb_ext;
         end
         if (coalesce) begin
            pending_mask <= pending_mask | chg;
         end else if (clr_pending) begin
            pending_mask <= '0;
         end
         if (coalesce) begin
            overflow <= 1'b1;
         end else if (clr_ovf) begin
            overflow <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_status_monitor.sv
// Self-checking bench for status_monitor: directed scenarios plus randomized
// traffic against a queue/sliding-window reference model.
module tb_status_monitor;

   localparam int          N_IN  = 6;
   localparam logic [11:0] INV   = 12'h020;
   localparam int          DEB   = 4;
   localparam int          DEPTH = 2;

   logic            clk     = 1'b0;
   logic            rst_n   = 1'b0;
   logic [N_IN-1:0] raw_in  = '0;
   logic            out_ack = 1'b0;
   logic            clr_ovf = 1'b0;
   logic [23:0]     out_data;
   logic            out_wr;
   logic            overflow;
   logic [N_IN-1:0] state;

   int checks = 0;
   int errors = 0;

   logic [N_IN-1:0] pipe_q[$];
   logic [N_IN-1:0] win_q[$];
   logic [23:0]     fifo_q[$];
   logic [N_IN-1:0] m_deb;
   logic [11:0]     m_last;
   logic [11:0]     m_pend;
   logic            m_ovf;
   logic            m_wr;
   logic [23:0]     m_data;

   always #5 clk = ~clk;

   status_monitor #(
      .N_IN             (N_IN),
      .INV_MASK         (INV),
      .DEB_CYCLES       (DEB),
      .FIFO_DEPTH       (DEPTH),
      .HEARTBEAT_CYCLES (50000)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .raw_in   (raw_in),
      .out_data (out_data),
      .out_wr   (out_wr),
      .out_ack  (out_ack),
      .overflow (overflow),
      .clr_ovf  (clr_ovf),
      .state    (state)
   );

`ifdef STATUS_MONITOR_HEARTBEAT_EN
   logic [N_IN-1:0] raw_hb = 6'b000011;
   logic [23:0]     hb_data;
   logic            hb_wr;
   logic            hb_ovf;
   logic [N_IN-1:0] hb_state;

   status_monitor #(
      .N_IN             (N_IN),
      .INV_MASK         (12'h000),
      .DEB_CYCLES       (DEB),
      .FIFO_DEPTH       (4),
      .HEARTBEAT_CYCLES (20)
   ) u_hb (
      .clk      (clk),
      .rst_n    (rst_n),
      .raw_in   (raw_hb),
      .out_data (hb_data),
      .out_wr   (hb_wr),
      .out_ack  (1'b1),
      .overflow (hb_ovf),
      .clr_ovf  (1'b0),
      .state    (hb_state)
   );
`endif

   task automatic model_reset();
      pipe_q.delete();
      pipe_q.push_back('0);
      pipe_q.push_back('0);
      win_q.delete();
      fifo_q.delete();
      m_deb  = '0;
      m_last = '0;
      m_pend = '0;
      m_ovf  = 1'b0;
      m_wr   = 1'b0;
      m_data = '0;
   endtask

   // Advances the model across the coming rising edge using the applied inputs.
   task automatic model_step();
      logic [N_IN-1:0] synced;
      logic [N_IN-1:0] flip;
      logic [11:0]     deb12;
      logic [11:0]     chg;
      logic            pop;
      logic            space;
      logic            do_push;
      logic            all_diff;
      logic [23:0]     word;
      if (!rst_n) begin
         model_reset();
         return;
      end
      pop   = m_wr && out_ack;
      space = (fifo_q.size() < DEPTH) || pop;
      if (pop) void'(fifo_q.pop_front());
      deb12   = {6'd0, m_deb};
      chg     = deb12 ^ m_last;
      do_push = 1'b0;
      word    = '0;
      if (clr_ovf) m_ovf = 1'b0;
      if (chg != 0) begin
         m_last = deb12;
         if (space) begin
            do_push = 1'b1;
            word    = {chg | m_pend, deb12};
            m_pend  = '0;
         end else begin
            m_pend = m_pend | chg;
            m_ovf  = 1'b1;
         end
      end else if (m_pend != 0 && space) begin
         do_push = 1'b1;
         word    = {m_pend, deb12};
         m_pend  = '0;
      end
      m_wr   = (fifo_q.size() != 0);
      m_data = m_wr ? fifo_q[0] : 24'h0;
      if (do_push) fifo_q.push_back(word);
      synced = pipe_q.pop_front();
      pipe_q.push_back(raw_in ^ INV[N_IN-1:0]);
      win_q.push_back(synced);
      if (win_q.size() > DEB) void'(win_q.pop_front());
      flip = '0;
      if (win_q.size() == DEB) begin
         for (int i = 0; i < N_IN; i++) begin
            all_diff = 1'b1;
            foreach (win_q[j]) if (win_q[j][i] == m_deb[i]) all_diff = 1'b0;
            flip[i] = all_diff;
         end
      end
      m_deb = m_deb ^ flip;
   endtask

   task automatic step();
      model_step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      raw_in  = 6'b100000;
      out_ack = 1'b0;
      clr_ovf = 1'b0;
      rst_n   = 1'b0;
      model_reset();
      repeat (3) step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      raw_in  = 6'b100000;
      rst_n   = 1'b0;
      model_reset();
      repeat (3) step();
      checks += 4;
      if (out_wr !== 1'b0) begin errors++; $display("[TB] FAIL reset.out_wr got %b exp 0", out_wr); end
      if (out_data !== 24'h0) begin errors++; $display("[TB] FAIL reset.out_data got %h exp 000000", out_data); end
      if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset.overflow got %b exp 0", overflow); end
      if (state !== 6'h0) begin errors++; $display("[TB] FAIL reset.state got %b exp 000000", state); end
      rst_n = 1'b1;
      repeat (100) step();
      checks += 3;
      if (out_wr !== 1'b0) begin errors++; $display("[TB] FAIL idle.out_wr got %b exp 0", out_wr); end
      if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL idle.overflow got %b exp 0", overflow); end
      if (state !== 6'h0) begin errors++; $display("[TB] FAIL idle.state got %b exp 000000", state); end
   endtask

   task automatic test_single_step();
      raw_in[0] = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         step();
         checks += 2;
         if (state !== ((c >= 6) ? 6'b000001 : 6'b000000)) begin
            errors++; $display("[TB] FAIL single.state c=%0d got %b", c, state);
         end
         if (out_wr !== (c >= 8)) begin
            errors++; $display("[TB] FAIL single.out_wr c=%0d got %b exp %b", c, out_wr, c >= 8);
         end
         if (c >= 8) begin
            checks++;
            if (out_data !== 24'h001001) begin
               errors++; $display("[TB] FAIL single.out_data c=%0d got %h exp 001001", c, out_data);
            end
         end
      end
      out_ack = 1'b1;
      step();
      out_ack = 1'b0;
      checks++;
      if (out_wr !== 1'b0) begin errors++; $display("[TB] FAIL single.after_ack got %b exp 0", out_wr); end
   endtask

   task automatic test_glitch();
      raw_in[2] = 1'b1;
      repeat (3) step();
      raw_in[2] = 1'b0;
      for (int c = 0; c < 15; c++) begin
         step();
         checks += 2;
         if (out_wr !== 1'b0) begin errors++; $display("[TB] FAIL glitch.out_wr c=%0d got %b exp 0", c, out_wr); end
         if (state !== 6'b000001) begin errors++; $display("[TB] FAIL glitch.state c=%0d got %b exp 000001", c, state); end
      end
   endtask

   task automatic test_coalesce();
      logic [23:0] exp_words [3];
      exp_words[0] = 24'h001001;
      exp_words[1] = 24'h002003;
      exp_words[2] = 24'h00C00F;
      do_reset();
      for (int b = 0; b < 4; b++) begin
         raw_in[b] = 1'b1;
         repeat (9) step();
      end
      checks += 2;
      if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL coalesce.overflow got %b exp 1", overflow); end
      if (state !== 6'b001111) begin errors++; $display("[TB] FAIL coalesce.state got %b exp 001111", state); end
      for (int w = 0; w < 3; w++) begin
         step();
         checks += 2;
         if (out_wr !== 1'b1) begin errors++; $display("[TB] FAIL coalesce.wr w=%0d got %b exp 1", w, out_wr); end
         if (out_data !== exp_words[w]) begin
            errors++; $display("[TB] FAIL coalesce.word w=%0d got %h exp %h", w, out_data, exp_words[w]);
         end
         out_ack = 1'b1;
         step();
         out_ack = 1'b0;
      end
      checks += 2;
      if (out_wr !== 1'b0) begin errors++; $display("[TB] FAIL coalesce.drained got %b exp 0", out_wr); end
      if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL coalesce.sticky got %b exp 1", overflow); end
      clr_ovf = 1'b1;
      step();
      clr_ovf = 1'b0;
      checks++;
      if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL coalesce.clr got %b exp 0", overflow); end
   endtask

   task automatic test_full_push_pop();
      logic [23:0] exp_words [3];
      exp_words[0] = 24'h001001;
      exp_words[1] = 24'h002003;
      exp_words[2] = 24'h004007;
      do_reset();
      raw_in[0] = 1'b1;
      repeat (9) step();
      raw_in[1] = 1'b1;
      repeat (9) step();
      raw_in[2] = 1'b1;
      repeat (6) step();
      checks++;
      if (out_data !== exp_words[0]) begin
         errors++; $display("[TB] FAIL fullpp.head got %h exp %h", out_data, exp_words[0]);
      end
      out_ack = 1'b1;
      step();
      out_ack = 1'b0;
      for (int w = 1; w < 3; w++) begin
         step();
         checks += 3;
         if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL fullpp.overflow w=%0d got %b exp 0", w, overflow); end
         if (out_wr !== 1'b1) begin errors++; $display("[TB] FAIL fullpp.wr w=%0d got %b exp 1", w, out_wr); end
         if (out_data !== exp_words[w]) begin
            errors++; $display("[TB] FAIL fullpp.word w=%0d got %h exp %h", w, out_data, exp_words[w]);
         end
         out_ack = 1'b1;
         step();
         out_ack = 1'b0;
      end
      checks++;
      if (out_wr !== 1'b0) begin errors++; $display("[TB] FAIL fullpp.drained got %b exp 0", out_wr); end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 7) == 0) raw_in[$urandom_range(0, N_IN - 1)] ^= 1'b1;
         out_ack = ($urandom_range(0, 3) == 0);
         clr_ovf = ($urandom_range(0, 40) == 0);
         if (c == 1500) begin
            rst_n = 1'b0;
            model_reset();
            step();
            step();
            rst_n = 1'b1;
         end
         step();
         checks += 4;
         if (out_wr !== m_wr) begin errors++; $display("[TB] FAIL rand.out_wr c=%0d got %b exp %b", c, out_wr, m_wr); end
         if (m_wr && out_data !== m_data) begin
            errors++; $display("[TB] FAIL rand.out_data c=%0d got %h exp %h", c, out_data, m_data);
         end
         if (state !== m_deb) begin errors++; $display("[TB] FAIL rand.state c=%0d got %b exp %b", c, state, m_deb); end
         if (overflow !== m_ovf) begin errors++; $display("[TB] FAIL rand.overflow c=%0d got %b exp %b", c, overflow, m_ovf); end
      end
      out_ack = 1'b0;
      clr_ovf = 1'b0;
   endtask

`ifdef STATUS_MONITOR_HEARTBEAT_EN
   task automatic test_heartbeat();
      logic        exp_wr;
      logic [23:0] exp_data;
      raw_hb = 6'b000011;
      do_reset();
      for (int e = 1; e <= 110; e++) begin
         step();
         exp_wr   = (e == 8 || e == 21 || e == 41 || e == 61 || e == 81 || e == 101);
         exp_data = (e == 8)   ? 24'h003003 :
                    (e == 81)  ? 24'h004007 :
                    (e == 101) ? 24'h000007 : 24'h000003;
         checks += 2;
         if (hb_wr !== exp_wr) begin errors++; $display("[TB] FAIL hb.wr e=%0d got %b exp %b", e, hb_wr, exp_wr); end
         if (hb_ovf !== 1'b0) begin errors++; $display("[TB] FAIL hb.overflow e=%0d got %b exp 0", e, hb_ovf); end
         if (exp_wr) begin
            checks++;
            if (hb_data !== exp_data) begin
               errors++; $display("[TB] FAIL hb.data e=%0d got %h exp %h", e, hb_data, exp_data);
            end
         end
         if (e == 73) raw_hb[2] = 1'b1;
      end
   endtask
`endif

   initial begin
      #500000;
      $display("[TB] FAIL watchdog time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      test_reset();
      test_single_step();
      test_glitch();
      test_coalesce();
      test_full_push_pop();
      test_random();
`ifdef STATUS_MONITOR_HEARTBEAT_EN
      test_heartbeat();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/status_monitor.md
Name: status_monitor

Overview:
- Parametrised, debounced status-input reporter: up to 12 raw lines (keys, lock sensors, limit switches) are synchronised, polarity-adjusted and debounced.
- Every change of the debounced vector is queued as an event word in a small FIFO.
- Events are presented on the existing 24-bit report channel with a valid/ack handshake, so no transition is lost while the host link is busy.

Parameters:
- N_IN, 6, number of input channels, 1..12.
- INV_MASK, 12'h00F, bit i=1 inverts raw input i before debouncing (active-low keys).
- DEB_CYCLES, 50000, consecutive stable cycles required to accept a new level, >=1.
- FIFO_DEPTH, 4, event FIFO entries, power of two, 2..16.
- HEARTBEAT_CYCLES, 10000000, heartbeat period (optional feature only).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset.
- raw_in  in  N_IN  asynchronous raw status lines.
- out_data  out  24  event word {changed[11:0], state[11:0]}, unused high bits of each field are 0.
- out_wr  out  1  event valid.
- out_ack  in  1  consumer accepts the current word this cycle.
- overflow  out  1  sticky: at least one event was coalesced; cleared by clr_ovf.
- clr_ovf  in  1  one-cycle clear of overflow.
- state  out  N_IN  current debounced vector.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: all outputs 0 (out_wr=0, out_data=0, overflow=0, state=0), synchronisers, debounce counters, last_reported and pending_mask 0, FIFO empty.
- Input conditioning: per channel, raw_in^INV_MASK passes through a 2-flop synchroniser.
  - Counter resets whenever the sync value equals deb[i].
  - Counter increments on each edge where the sync value differs from deb[i].
  - deb[i] toggles on the DEB_CYCLES-th consecutive differing edge. The counter then clears.
  - Counter width is clog2(DEB_CYCLES+1).
- Debounce latency: a raw step stable from edge k sets deb at edge k+2+DEB_CYCLES. A glitch shorter than DEB_CYCLES cycles at the sync output produces no change.
- Change detect: chg = deb ^ last_reported, evaluated every cycle.
- When chg!=0:
  - FIFO not full (or popping this cycle): push {chg|pending_mask, deb}; last_reported<=deb; pending_mask<=0. The push lands at edge k+3+DEB_CYCLES.
  - FIFO full and not popping: no push; pending_mask|=chg; last_reported<=deb; overflow<=1. The next push carries the accumulated mask with the then-current state.
- When chg==0 and pending_mask!=0 and space exists: push {pending_mask, deb}; clear pending_mask.
- Output handshake:
  - out_wr = FIFO non-empty; out_data = head entry.
  - out_data is stable while out_wr && !out_ack.
  - Pop on out_wr && out_ack. out_ack while out_wr=0 is ignored.
  - The FIFO is first-word-fall-through. A push into an empty FIFO raises out_wr on the following cycle (registered head).
- Simultaneous push and pop when full: both occur, occupancy unchanged, no coalescing.
- clr_ovf and a coalesce in the same cycle: overflow stays 1 (set wins).
- Reset mid-operation: FIFO flushed, pending_mask cleared, debounced state returns to 0. Inputs already active re-report after debounce.
- Pointers: log2(FIFO_DEPTH)+1 bits, full/empty from MSB compare, wrap modulo depth.

Optional Feature:
- Macro: STATUS_MONITOR_HEARTBEAT_EN.
- When defined:
  - A free-running counter pushes {12'b0, deb} every HEARTBEAT_CYCLES cycles (changed=0) if the FIFO has space.
  - A change event in the same cycle takes priority. The heartbeat is skipped and its counter restarts.
  - A heartbeat is never coalesced and never sets overflow.
- When undefined: no counter logic, HEARTBEAT_CYCLES unused, events only on change.

Decomposition:
- Shared package status_pkg:
  - STATUS_MAX_IN=12.
  - Event word field offsets (CHG_LSB=12, STATE_LSB=0).
  - Event struct/typedef.
  - clog2 function.
- One natural sub-module: status_debounce (synchroniser plus counter, one channel), instantiated N_IN times in a generate loop.
- FIFO stays inline.

Test Plan:
- Reset/idle: hold rst_n=0 with raw_in=0, release, run 100 cycles at DEB_CYCLES=4 -> out_wr=0, state=0, overflow=0.
- Single step: raw_in[0] 0->1 at edge 10, INV_MASK=0, DEB_CYCLES=4 -> state[0]=1 at edge 16. out_wr=1 with out_data=24'h001001 from edge 18 until out_ack, then out_wr=0.
- Glitch rejection: 3-cycle pulse on raw_in[2] with DEB_CYCLES=4 -> no event, state unchanged.
- Backpressure/coalesce: FIFO_DEPTH=2, out_ack=0, toggle inputs 0,1,2,3 sequentially -> 2 events queued, overflow=1. After acking both, a third word carries changed=0x00C and state=0x00F.
- Simultaneous full push/pop: FIFO full, out_ack=1 in the cycle a new change arrives -> no coalesce, overflow stays 0, order preserved.
- Heartbeat (macro defined, HEARTBEAT_CYCLES=20, stable inputs, out_ack=1) -> word {12'h000, state} every 20 cycles. A change in the same cycle emits only the change event.
